l1i_refill: RTL

Miss handler and line writer for the L1 instruction cache. It accepts a miss address from the fetch-side lookup, requests the full line from the next memory level as 32-bit beats, and assembles the line. It then writes the line, tag and valid bit into one way of the indexed set. It also runs a full-cache invalidate sweep.

---
 rtl/l1i_refill_pkg.sv | 33 +++
 rtl/l1i_victim_sel.sv | 37 +++
 rtl/l1i_refill.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/l1i_refill_pkg.sv
// Shared types and constants for the L1 instruction-cache refill path.
// The critical-word-first option is selected with L1I_REFILL_CWF_EN (see l1i_refill.sv).
package l1i_refill_pkg;

    localparam int L1I_OFFSET_BITS = 4;
    localparam int L1I_SET_BITS    = 5;
    localparam int L1I_WAYS        = 2;
    localparam int L1I_TAG_BITS    = 32 - L1I_SET_BITS - L1I_OFFSET_BITS;
    localparam int BEATS_PER_LINE  = (1 << L1I_OFFSET_BITS) / 4;

    typedef logic [L1I_TAG_BITS-1:0]      tag_t;
    typedef logic [L1I_SET_BITS-1:0]      set_t;
    typedef logic [BEATS_PER_LINE*32-1:0] line_t;

    typedef struct packed {
        logic  valid;
        tag_t  tag;
        line_t line;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_FILL,
        S_WRITE,
        S_INV
    } state_t;

    function automatic int beats_per_line(input int offset_bits);
        return (1 << offset_bits) / 4;
    endfunction

endpackage

// File: rtl/l1i_victim_sel.sv
// Per-set round-robin victim pointers: combinational read, single-set advance,
// and a clear-all used by the invalidate sweep.
module l1i_victim_sel
    import l1i_refill_pkg::*;
#(
    parameter int SET_BITS = L1I_SET_BITS,
    parameter int WAYS     = L1I_WAYS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SET_BITS-1:0]      rd_set,
    output logic [$clog2(WAYS)-1:0]  rd_way,
    input  logic                     advance,
    input  logic [SET_BITS-1:0]      adv_set,
    input  logic                     clear_all
);

    localparam int NSETS = 1 << SET_BITS;

    logic [$clog2(WAYS)-1:0] ptr [NSETS];

    // NOTE: this array is built from flops, not a RAM macro, so it can take an
    // async reset; a real SRAM here would instead need a clearing sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSETS; i++) ptr[i] <= '0;
        end else if (clear_all) begin
            for (int i = 0; i < NSETS; i++) ptr[i] <= '0;
        end else if (advance) begin
            // WAYS is a power of two, so natural wrap gives mod WAYS.
            ptr[adv_set] <= ptr[adv_set] + 1'b1;
        end
    end

    assign rd_way = ptr[rd_set];

endmodule

// File: rtl/l1i_refill.sv
// L1I miss handler: requests a line as 32-bit beats, assembles it, writes it to
// the round-robin victim way, and runs the invalidate-all sweep. Option: L1I_REFILL_CWF_EN.
module l1i_refill
    import l1i_refill_pkg::*;
#(
    parameter int OFFSET_BITS = L1I_OFFSET_BITS,
    parameter int SET_BITS    = L1I_SET_BITS,
    parameter int TAG_BITS    = 32 - SET_BITS - OFFSET_BITS,
    parameter int WAYS        = L1I_WAYS
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   miss_valid,
    output logic                                   miss_ready,
    input  logic [31:0]                            miss_addr,
    input  logic                                   inv_req,
    output logic                                   busy,
    output logic                                   mem_req_valid,
    input  logic                                   mem_req_ready,
    output logic [31:0]                            mem_req_addr,
    input  logic                                   mem_resp_valid,
    output logic                                   mem_resp_ready,
    input  logic [31:0]                            mem_resp_data,
    input  logic                                   mem_resp_err,
    output logic                                   wr_en,
    output logic [$clog2(WAYS)-1:0]                wr_way,
    output logic [SET_BITS-1:0]                    wr_set,
    output logic [TAG_BITS+(1<<OFFSET_BITS)*8:0]   wr_entry,
    output logic                                   done,
    output logic                                   err,
    output logic                                   fwd_valid,
    output logic [31:0]                            fwd_data
);

    localparam int N         = beats_per_line(OFFSET_BITS);
    localparam int WORD_BITS = OFFSET_BITS - 2;
    localparam int WAY_BITS  = $clog2(WAYS);
    localparam int LINE_BITS = N * 32;
    localparam int INV_BITS  = SET_BITS + WAY_BITS;

    localparam logic [WORD_BITS-1:0] LAST_BEAT = '1;
    localparam logic [INV_BITS-1:0]  INV_LAST  = '1;

    state_t                state;
    logic [TAG_BITS-1:0]   tag_q;
    logic [SET_BITS-1:0]   set_q;
    logic [WORD_BITS-1:0]  start_q;
    logic [WORD_BITS-1:0]  cnt_q;
    logic [LINE_BITS-1:0]  line_q;
    logic [LINE_BITS-1:0]  line_next;
    logic [INV_BITS-1:0]   inv_cnt;
    logic [INV_BITS-1:0]   inv_next;
    logic [WAY_BITS-1:0]   victim_way;
    logic [WORD_BITS-1:0]  word_idx;
    logic [WORD_BITS-1:0]  start_idx;
    logic [31:0]           req_addr_next;
    logic [TAG_BITS-1:0]   miss_tag;
    logic [SET_BITS-1:0]   miss_set;

    assign miss_tag = miss_addr[31 -: TAG_BITS];
    assign miss_set = miss_addr[OFFSET_BITS +: SET_BITS];

`ifdef L1I_REFILL_CWF_EN
    logic unused_byte_bits;
    assign unused_byte_bits = ^miss_addr[1:0];
    assign start_idx        = miss_addr[2 +: WORD_BITS];
    assign req_addr_next    = {miss_addr[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_valid <= 1'b0;
            fwd_data  <= '0;
        end else begin
            // The first accepted beat is the requested word itself.
            fwd_valid <= 1'b0;
            if (state == S_FILL && mem_resp_valid && !mem_resp_err && cnt_q == '0) begin
                fwd_valid <= 1'b1;
                fwd_data  <= mem_resp_data;
            end
        end
    end
`else
    logic unused_offset_bits;
    assign unused_offset_bits = ^miss_addr[OFFSET_BITS-1:0];
    assign start_idx          = '0;
    assign req_addr_next      = {miss_tag, miss_set, {OFFSET_BITS{1'b0}}};
    assign fwd_valid          = 1'b0;
    assign fwd_data           = '0;
`endif

    // Word index wraps naturally because N is a power of two.
    assign word_idx = start_q + cnt_q;
    assign inv_next = inv_cnt + 1'b1;

    // NOTE: always_comb gives every output a default first so no latch is inferred.
    always_comb begin
        line_next = line_q;
        line_next[{word_idx, 5'd0} +: 32] = mem_resp_data;
    end

    assign miss_ready = (state == S_IDLE) && !inv_req;
    assign busy       = (state != S_IDLE);

    l1i_victim_sel #(
        .SET_BITS (SET_BITS),
        .WAYS     (WAYS)
    ) u_victim (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_set    (set_q),
        .rd_way    (victim_way),
        .advance   (state == S_WRITE),
        .adv_set   (set_q),
        .clear_all (state == S_INV)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            tag_q          <= '0;
            set_q          <= '0;
            start_q        <= '0;
            cnt_q          <= '0;
            line_q         <= '0;
            inv_cnt        <= '0;
            mem_req_valid  <= 1'b0;
            mem_req_addr   <= '0;
            mem_resp_ready <= 1'b0;
            wr_en          <= 1'b0;
            wr_way         <= '0;
            wr_set         <= '0;
            wr_entry       <= '0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (inv_req) begin
                        state    <= S_INV;
                        inv_cnt  <= '0;
                        wr_en    <= 1'b1;
                        wr_set   <= '0;
                        wr_way   <= '0;
                        wr_entry <= '0;
                    end else if (miss_valid) begin
                        state         <= S_REQ;
                        tag_q         <= miss_tag;
                        set_q         <= miss_set;
                        start_q       <= start_idx;
                        line_q        <= '0;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= req_addr_next;
                    end
                end

                S_REQ: begin
                    if (mem_req_ready) begin
                        state          <= S_FILL;
                        mem_req_valid  <= 1'b0;
                        mem_resp_ready <= 1'b1;
                        cnt_q          <= '0;
                    end
                end

                S_FILL: begin
                    if (mem_resp_valid) begin
                        if (mem_resp_err) begin
                            state          <= S_IDLE;
                            mem_resp_ready <= 1'b0;
                            line_q         <= '0;
                            err            <= 1'b1;
                        end else begin
                            line_q <= line_next;
                            cnt_q  <= cnt_q + 1'b1;
                            if (cnt_q == LAST_BEAT) begin
                                // Last beat: present the write during the WRITE cycle.
                                state          <= S_WRITE;
                                mem_resp_ready <= 1'b0;
                                wr_en          <= 1'b1;
                                done           <= 1'b1;
                                wr_way         <= victim_way;
                                wr_set         <= set_q;
                                wr_entry       <= {1'b1, tag_q, line_next};
                            end
                        end
                    end
                end

                S_WRITE: begin
                    state <= S_IDLE;
                end

                S_INV: begin
                    if (inv_cnt == INV_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        inv_cnt           <= inv_next;
                        wr_en             <= 1'b1;
                        {wr_set, wr_way}  <= inv_next;
                        wr_entry          <= '0;
                        done              <= (inv_next == INV_LAST);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
